// File: rtl/fp_accum_seq.sv
// fp_accum_seq: upstream sequencer for the single-precision adder block.
//
// Accepts float32 operands on a valid/ready input stream. Each vector is folded
// into a running sum by issuing one start/done transaction per element to an
// external adder. The final sum, a saturating element count and a timeout
// error flag are presented on a valid/ready output. No float arithmetic is
// done here; special values are carried through untouched.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds valid and its payload stable
// until that edge. Here in_ready and out_valid are decoded only from the state
// register, so they never depend combinationally on in_valid or out_ready.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   operand valid
//   in_ready   operand accepted when in_valid & in_ready
//   in_data    float32 operand
//   in_last    marks the last element of a vector
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_data   accumulated float32 sum
//   out_count  element count of the vector (saturating)
//   out_err    at least one addition in this vector timed out
//   add_start  one-cycle start pulse to the adder
//   add_a      adder operand a: running sum
//   add_b      adder operand b: new element
//   add_sum    adder result
//   add_done   adder completion level, held until the next start
//   state_dbg  current FSM state encoding, for observation only
module fp_accum_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic [2:0]       state_dbg
);

  // One extra bit so TIMEOUT-1 always fits, whatever TIMEOUT is.
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_FIRST = 3'd0,
    ST_NEXT  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      b_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_FIRST;
      acc    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
      tmr    <= '0;
    end else begin
      case (state)
        ST_FIRST: begin
          // The first element seeds the sum directly; no adder transaction.
          if (in_valid) begin
            acc   <= in_data;
            cnt   <= CNT_ONE;
            err   <= 1'b0;
            state <= in_last ? ST_OUT : ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (in_valid) begin
            b_q    <= in_data;
            last_q <= in_last;
            // Saturation only limits the reported count; summing goes on.
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            state  <= ST_START;
          end
        end
        ST_START: begin
          tmr   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The adder clears done on the start edge, so a high done here
          // always belongs to the current operation.
          if (add_done) begin
            acc   <= add_sum;
            state <= last_q ? ST_OUT : ST_NEXT;
          end else if (tmr == TMR_LAST) begin
            // Abandon the addition: keep the old sum and flag the vector.
            err   <= 1'b1;
            state <= last_q ? ST_OUT : ST_NEXT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_FIRST;
        end
        default: state <= ST_FIRST;
      endcase
    end
  end

  // Everything below is a pure decode of registers.
  assign in_ready  = (state == ST_FIRST) || (state == ST_NEXT);
  assign out_valid = (state == ST_OUT);
  assign add_start = (state == ST_START);
  assign out_data  = acc;
  assign out_count = cnt;
  assign out_err   = err;
  assign add_a     = acc;
  assign add_b     = b_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: a latency-randomised adder model, a real-arithmetic
// reference for vector sums, an expected-result queue checked on every output
// handshake, and directed cases with hand-computed float32 constants.
module tb_fp_accum_seq;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EXP_W   = 1 + CNT_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, in_last;
  logic [31:0]      in_data;
  logic             out_valid, out_ready, out_err;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             add_start, add_done;
  logic [31:0]      add_a, add_b, add_sum;
  logic [2:0]       state_dbg;

  fp_accum_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_err(out_err),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- float helpers (exact for the values used here) ----------------
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'(longint'((a - 1.0) * 8388608.0))};
  endfunction

  // ---------------- adder model ----------------
  // Clears done on the start edge; raises done with the sum after a random
  // latency. The sum is formed from add_a/add_b at completion, so operands
  // that drift during WAIT give a wrong result.
  int lat_min = 1;
  int lat_max = 5;
  bit hang    = 1'b0;
  int cd;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_done <= 1'b0;
      add_sum  <= 32'h0;
      cd       <= 0;
    end else if (add_start) begin
      add_done <= 1'b0;
      add_sum  <= 32'hDEAD_BEEF;
      cd       <= hang ? 0 : int'($urandom_range(lat_max, lat_min));
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        add_done <= 1'b1;
        add_sum  <= r2f(f2r(add_a) + f2r(add_b));
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int   n_start   = 0;
  int   start_cyc = 0;
  int   last_lat  = 0;
  bit   hold_prev = 1'b0;
  bit   ov_prev   = 1'b0;
  logic [EXP_W-1:0] held;

  task automatic push_exp(input logic [31:0] d, input int n, input bit e);
    int c;
    c = (n > CNT_MAX) ? CNT_MAX : n;
    exp_q.push_back({e, CNT_W'(c), d});
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset) begin
      hold_prev = 1'b0;
      ov_prev   = 1'b0;
    end else begin
      chk("ready_valid_exclusive", {63'd0, in_ready & out_valid}, 64'd0);
      if (add_start) begin
        n_start++;
        start_cyc = cyc;
        chk("start_while_idle", {62'd0, in_ready, out_valid}, 64'd0);
      end
      if (out_valid && !ov_prev) last_lat = cyc - start_cyc;
      if (hold_prev) begin
        chk("out_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("out_hold_fields", 64'({out_err, out_count, out_data}), 64'(held));
        chk("out_hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'({out_err, out_count, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'({out_err, out_count, out_data}), 64'(e));
          end
          hold_prev = 1'b0;
        end else begin
          hold_prev = 1'b1;
          held      = {out_err, out_count, out_data};
        end
      end else begin
        hold_prev = 1'b0;
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 1;  // 1: random out_ready, 0: driven by the main sequence
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input bit last);
    int w;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) chk("in_ready_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin @(posedge clk); #1; w++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_rand_vec(input int n);
    real sum;
    real v[$];
    sum = 0.0;
    for (int i = 0; i < n; i++) begin
      v.push_back(real'(int'($urandom_range(400, 0)) - 200) / 2.0);
      sum = sum + v[i];
    end
    push_exp(r2f(sum), n, 1'b0);
    for (int i = 0; i < n; i++) send(r2f(v[i]), i == n - 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    int w;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_err",   {63'd0, out_err}, 64'd0);
    chk("rst_add_start", {63'd0, add_start}, 64'd0);
    chk("rst_add_ab",    {add_a, add_b}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1 + 2 + 3 = 6, two adder transactions
    n0 = n_start;
    push_exp(32'h40C00000, 3, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    drain();
    chk("starts_123", 64'(n_start - n0), 64'd2);

    // single element passes straight through, no adder transaction
    n0 = n_start;
    push_exp(32'h40490FDB, 1, 1'b0);
    send(32'h40490FDB, 1'b1);
    drain();
    chk("starts_single", 64'(n_start - n0), 64'd0);

    // 1.5 + -1.5 = +0
    push_exp(32'h00000000, 2, 1'b0);
    send(32'h3FC00000, 1'b0);
    send(32'hBFC00000, 1'b1);
    drain();

    // output held while out_ready is low: 7 + 8 = 15
    ready_mode = 0;
    out_ready  = 1'b0;
    push_exp(32'h41700000, 2, 1'b0);
    send(32'h40E00000, 1'b0);
    send(32'h41000000, 1'b1);
    w = 0;
    while (!out_valid && w < 500) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold5_valid", {63'd0, out_valid}, 64'd1);
      chk("hold5_data",  64'(out_data), 64'h41700000);
      chk("hold5_count", 64'(out_count), 64'd2);
      chk("hold5_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ready_mode = 1;
    drain();

    // adder never finishes: 2.0 kept, error flagged after TIMEOUT WAIT cycles
    hang = 1'b1;
    push_exp(32'h40000000, 2, 1'b1);
    send(32'h40000000, 1'b0);
    send(32'h40A00000, 1'b1);
    drain();
    chk("timeout_latency", 64'(last_lat), 64'(TIMEOUT + 1));
    hang = 1'b0;
    push_exp(32'h40000000, 2, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    drain();

    // reset in the middle of WAIT discards the partial vector
    lat_min = 20;
    lat_max = 20;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_add_start", {63'd0, add_start}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("mid_rst_add_ab",    {add_a, add_b}, 64'd0);
    @(posedge clk); #1;
    reset   = 1'b1;
    lat_min = 1;
    lat_max = 5;
    push_exp(32'h40800000, 1, 1'b0);
    send(32'h40800000, 1'b1);
    drain();

    // count saturates at 255 while the sum keeps going: 258 x 1.0
    lat_max = 2;
    push_exp(32'h43810000, 258, 1'b0);
    for (int i = 0; i < 258; i++) send(32'h3F800000, i == 257);
    drain();
    lat_max = 5;

    // randomised vectors against the real-arithmetic reference
    for (int v = 0; v < 25; v++) send_rand_vec(int'($urandom_range(8, 1)));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
